// File: rtl/pw_conv_pkg.sv
// rtl/pw_conv_pkg.sv - shared types, default widths and helpers for the pointwise conv array
package pw_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_NUM_OC    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_MAX_IN_CH = 320;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pw_dot_lane.sv
// rtl/pw_dot_lane.sv - one output channel's masked signed dot product over a beat, registered
// as the stage-1 lane sum and sign-extended to the accumulator width.
module pw_dot_lane
  import pw_conv_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_i,
  input  logic [NUM_LANES-1:0]        mask_i,
  input  logic [NUM_LANES*DATA_W-1:0] act_i,
  input  logic [NUM_LANES*DATA_W-1:0] wgt_i,
  output logic [ACC_W-1:0]            lane_sum_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  lane_sum_q;

  always_comb begin
    prod  = '0;
    sum_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      prod = PROD_W'($signed(act_i[i*DATA_W +: DATA_W])) *
             PROD_W'($signed(wgt_i[i*DATA_W +: DATA_W]));
      if (mask_i[i]) begin
        sum_d = sum_d + SUM_W'(prod);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_sum_q <= '0;
    end else if (load_i) begin
      lane_sum_q <= ACC_W'(sum_d);
    end
  end

  assign lane_sum_o = lane_sum_q;

endmodule

// File: rtl/pointwise_conv1x1_array.sv
// rtl/pointwise_conv1x1_array.sv - NUM_OC-wide pointwise 1x1 convolution engine with
// bias-initialised accumulators, tail-lane masking and optional ReLU on the result.
module pointwise_conv1x1_array
  import pw_conv_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_OC    = DEF_NUM_OC,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_IN_CH = DEF_MAX_IN_CH,
  parameter int CH_W      = $clog2(MAX_IN_CH + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CH_W-1:0]                    cfg_in_ch,
  input  logic                               cfg_relu,
  input  logic [NUM_OC*ACC_W-1:0]            bias,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_LANES*DATA_W-1:0]        in_act,
  input  logic [NUM_OC*NUM_LANES*DATA_W-1:0] in_wgt,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_OC*ACC_W-1:0]            out_data,
  output logic                               busy,
  output logic                               cfg_err
);

  localparam int              LANE_W = $clog2(NUM_LANES) + 1;
  localparam logic [CH_W-1:0] MAX_CH = CH_W'(MAX_IN_CH);

  state_t                    state_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic                      cfg_err_q;
  logic                      relu_q;
  logic                      s1_valid_q;
  logic [CH_W-1:0]           beats_q;
  logic [CH_W-1:0]           beat_cnt_q;
  logic [LANE_W-1:0]         rem_q;
  logic [NUM_OC*ACC_W-1:0]   acc_q;
  logic [NUM_OC*ACC_W-1:0]   out_data_q;
  logic [NUM_OC*ACC_W-1:0]   out_data_d;
  logic [NUM_OC*ACC_W-1:0]   lane_sum;
  logic [NUM_LANES-1:0]      lane_mask;
  logic                      accept;
  logic                      last_beat;
  logic                      cfg_legal;

  assign accept    = in_valid && in_ready_q;
  assign last_beat = (beat_cnt_q == beats_q - 1'b1);
  assign cfg_legal = (cfg_in_ch != '0) && (cfg_in_ch <= MAX_CH);

  // Only the final beat of a non-multiple channel count carries dead lanes.
  always_comb begin
    lane_mask = '1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (last_beat && (rem_q != '0) && (32'(rem_q) <= i)) begin
        lane_mask[i] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_OC; k++) begin : g_oc
    pw_dot_lane #(
      .NUM_LANES(NUM_LANES),
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W)
    ) u_dot (
      .clock     (clock),
      .reset     (reset),
      .load_i    (accept),
      .mask_i    (lane_mask),
      .act_i     (in_act),
      .wgt_i     (in_wgt[k*NUM_LANES*DATA_W +: NUM_LANES*DATA_W]),
      .lane_sum_o(lane_sum[k*ACC_W +: ACC_W])
    );
  end

  always_comb begin
    out_data_d = acc_q;
    for (int k = 0; k < NUM_OC; k++) begin
      if (relu_q && acc_q[k*ACC_W + ACC_W - 1]) begin
        out_data_d[k*ACC_W +: ACC_W] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      relu_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
    end else begin
      cfg_err_q  <= 1'b0;
      s1_valid_q <= accept;
      if (s1_valid_q) begin
        for (int k = 0; k < NUM_OC; k++) begin
          acc_q[k*ACC_W +: ACC_W] <= acc_q[k*ACC_W +: ACC_W] + lane_sum[k*ACC_W +: ACC_W];
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              relu_q     <= cfg_relu;
              beats_q    <= CH_W'(ceil_div(32'(cfg_in_ch), 32'(NUM_LANES)));
              rem_q      <= LANE_W'(32'(cfg_in_ch) % 32'(NUM_LANES));
              beat_cnt_q <= '0;
              acc_q      <= bias;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ACCUM;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Wait until stage 2 has folded the final lane sum into acc.
          if (!s1_valid_q) begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pointwise_conv1x1_array.sv
// tb/tb_pointwise_conv1x1_array.sv - table-driven and randomized checks of the pointwise conv array
module tb_pointwise_conv1x1_array;

  localparam int NL = 16;
  localparam int NOC = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int MAXC = 320;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [8:0]             cfg_in_ch;
  logic                   cfg_relu;
  logic [NOC*AW-1:0]      bias;
  logic                   in_valid;
  logic                   in_ready;
  logic [NL*DW-1:0]       in_act;
  logic [NOC*NL*DW-1:0]   in_wgt;
  logic                   out_valid;
  logic                   out_ready;
  logic [NOC*AW-1:0]      out_data;
  logic                   busy;
  logic                   cfg_err;

  pointwise_conv1x1_array dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cfg_in_ch(cfg_in_ch),
    .cfg_relu (cfg_relu),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_act   (in_act),
    .in_wgt   (in_wgt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]      in_ch;
    logic             relu;
    logic [31:0]      bias;
    logic [31:0]      act;
    logic [3:0][31:0] wgt;
    logic             poke;
    logic [31:0]      gap;
    logic [31:0]      stall;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   vectors = 0;
  int   miscompares = 0;
  int   act_mem[MAXC+NL];
  int   wgt_mem[NOC][MAXC+NL];
  int   bias_arr[NOC];
  int   got_arr[NOC];
  int   exp_arr[NOC];

  function automatic vec_t mk(int in_ch, bit relu, int b, int act, int w0, int w1, int w2, int w3,
                              bit poke, int gap, int stall, int e0, int e1, int e2, int e3);
    vec_t v;
    v.in_ch = in_ch; v.relu = relu; v.bias = b; v.act = act;
    v.wgt[0] = w0; v.wgt[1] = w1; v.wgt[2] = w2; v.wgt[3] = w3;
    v.poke = poke; v.gap = gap; v.stall = stall;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: bias plus the plain channel-by-channel dot product, then optional clamp.
  task automatic model(input int in_ch, input bit relu);
    for (int k = 0; k < NOC; k++) begin
      int s;
      s = bias_arr[k];
      for (int c = 0; c < in_ch; c++) s += act_mem[c] * wgt_mem[k][c];
      exp_arr[k] = (relu && s < 0) ? 0 : s;
    end
  endtask

  task automatic drive_beat(input int b, input int in_ch);
    for (int i = 0; i < NL; i++) begin
      int c;
      c = b * NL + i;
      in_act[i*DW +: DW] = (c < in_ch) ? 8'(act_mem[c]) : 8'd127;
      for (int k = 0; k < NOC; k++)
        in_wgt[(k*NL+i)*DW +: DW] = (c < in_ch) ? 8'(wgt_mem[k][c]) : 8'd127;
    end
  endtask

  // Entered and left at a negedge.
  task automatic run_job(input string tag, input int in_ch, input bit relu, input int gap,
                         input int stall, input bit poke);
    int beats, b, it, lat;
    logic [NOC*AW-1:0] hold;
    bit acc;
    beats = (in_ch + NL - 1) / NL;
    start = 1'b1; cfg_in_ch = 9'(in_ch); cfg_relu = relu;
    for (int k = 0; k < NOC; k++) bias[k*AW +: AW] = bias_arr[k];
    out_ready = (stall == 0);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_in_ready_after_start"}, in_ready, 1);
    check({tag, "_busy_after_start"}, busy, 1);
    b = 0; it = 0;
    while (b < beats && it < 2000) begin
      if (gap == 1) in_valid = (it % 2 == 0);
      else if (gap == 2) in_valid = 1'($urandom % 2);
      else in_valid = 1'b1;
      drive_beat(b, in_ch);
      if (poke && it == 0) begin
        start = 1'b1; cfg_in_ch = 9'd0; cfg_relu = ~relu; bias = '1;
      end
      acc = in_valid && in_ready;
      @(negedge clock);
      if (acc) b++;
      it++;
      if (poke && it == 1) begin
        start = 1'b0;
        check({tag, "_poke_no_cfg_err"}, cfg_err, 0);
      end
    end
    in_valid = 1'b0;
    check({tag, "_beats_accepted"}, b, beats);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    hold = out_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check({tag, "_stall_hold"}, (out_data == hold) && out_valid && !in_ready, 1);
    end
    for (int k = 0; k < NOC; k++) got_arr[k] = $signed(out_data[k*AW +: AW]);
    out_ready = 1'b1;
    @(negedge clock);
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_in_ch = '0; cfg_relu = 1'b0; bias = '0;
    in_valid = 1'b0; in_act = '0; in_wgt = '0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data_zero", out_data == '0, 1);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);

    tbl[0] = mk(16, 0, 0, 1, 1, 2, 3, 4, 0, 0, 0, 16, 32, 48, 64);
    tbl[1] = mk(20, 0, 0, 2, 3, 3, 3, 3, 0, 0, 0, 120, 120, 120, 120);
    tbl[2] = mk(16, 1, -5, -128, 127, 127, 127, 127, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(16, 0, -5, -128, 127, 127, 127, 127, 0, 0, 0, -260101, -260101, -260101, -260101);
    tbl[4] = mk(32, 0, 100, 3, -2, 5, 0, -7, 0, 1, 5, -92, 580, 100, -572);
    tbl[5] = mk(320, 0, 7, -1, 1, -1, 2, -2, 0, 0, 0, -313, 327, -633, 647);
    tbl[6] = mk(1, 1, 10, 5, 3, -4, 0, 127, 0, 0, 0, 25, 0, 10, 645);
    tbl[7] = mk(48, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 48, 48, 48, 48);

    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < MAXC; c++) begin
        act_mem[c] = $signed(tbl[v].act);
        for (int k = 0; k < NOC; k++) wgt_mem[k][c] = $signed(tbl[v].wgt[k]);
      end
      for (int k = 0; k < NOC; k++) bias_arr[k] = $signed(tbl[v].bias);
      run_job($sformatf("tbl%0d", v), tbl[v].in_ch, tbl[v].relu, tbl[v].gap, tbl[v].stall, tbl[v].poke);
      for (int k = 0; k < NOC; k++)
        check($sformatf("tbl%0d_oc%0d", v, k), got_arr[k], $signed(tbl[v].exp[k]));
    end

    // Illegal configurations pulse cfg_err for one cycle and never leave IDLE.
    for (int j = 0; j < 2; j++) begin
      start = 1'b1; cfg_in_ch = (j == 0) ? 9'd0 : 9'd321;
      @(negedge clock);
      start = 1'b0;
      check($sformatf("cfg_err_pulse%0d", j), cfg_err, 1);
      check($sformatf("cfg_err_busy%0d", j), busy, 0);
      @(negedge clock);
      check($sformatf("cfg_err_clear%0d", j), cfg_err, 0);
    end

    // Reset after one of three beats, then a fresh single-beat job.
    for (int c = 0; c < MAXC; c++) begin
      act_mem[c] = 1;
      for (int k = 0; k < NOC; k++) wgt_mem[k][c] = 1;
    end
    start = 1'b1; cfg_in_ch = 9'd48; cfg_relu = 1'b0; bias = '0;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; drive_beat(0, 48);
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    for (int c = 0; c < MAXC; c++) act_mem[c] = 2;
    for (int k = 0; k < NOC; k++) bias_arr[k] = 0;
    run_job("after_rst", 16, 0, 0, 0, 0);
    for (int k = 0; k < NOC; k++) check($sformatf("after_rst_oc%0d", k), got_arr[k], 32);

    for (int r = 0; r < 6; r++) begin
      int in_ch;
      bit relu;
      in_ch = $urandom_range(1, MAXC);
      relu = 1'($urandom % 2);
      for (int c = 0; c < MAXC; c++) begin
        act_mem[c] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < NOC; k++) wgt_mem[k][c] = int'($urandom_range(0, 255)) - 128;
      end
      for (int k = 0; k < NOC; k++) bias_arr[k] = int'($urandom_range(0, 2000000)) - 1000000;
      model(in_ch, relu);
      run_job($sformatf("rnd%0d", r), in_ch, relu, 2, $urandom_range(0, 3), 0);
      for (int k = 0; k < NOC; k++)
        check($sformatf("rnd%0d_ch%0d_oc%0d", r, in_ch, k), got_arr[k], exp_arr[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pointwise_conv1x1_array.md
# pointwise_conv1x1_array

Multi-output-channel pointwise 1×1 convolution engine for the MobileNetV2 expansion and projection layers. It computes NUM_OC output channels of one spatial position in parallel by streaming input-channel beats of NUM_LANES signed activations and weights. Each output is signed, bias-initialised and optionally ReLU-clamped. It sits between the activation line buffer and the requantiser, and uses valid/ready handshakes on both sides so either neighbour can stall it.

## Interface
Parameters:
- NUM_LANES, 16, input channels consumed per beat
- NUM_OC, 4, output channels computed in parallel
- DATA_W, 8, signed activation/weight width
- ACC_W, 32, signed accumulator/output width
- MAX_IN_CH, 320, largest supported input-channel count; CH_W = $clog2(MAX_IN_CH+1)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a new output vector; honoured only in IDLE
- cfg_in_ch  in  CH_W  input-channel count, sampled on start
- cfg_relu  in  1  clamp negative outputs to 0, sampled on start
- bias  in  NUM_OC*ACC_W  per-OC signed bias, sampled on start; OC k at [k*ACC_W +: ACC_W]
- in_valid  in  1  beat available
- in_ready  out  1  engine accepts beat
- in_act  in  NUM_LANES*DATA_W  activations; lane i at [i*DATA_W +: DATA_W]
- in_wgt  in  NUM_OC*NUM_LANES*DATA_W  weights; OC k, lane i at [(k*NUM_LANES+i)*DATA_W +: DATA_W]
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- out_data  out  NUM_OC*ACC_W  results, same packing as bias
- busy  out  1  high whenever not IDLE
- cfg_err  out  1  one-cycle pulse: start seen with cfg_in_ch==0 or cfg_in_ch>MAX_IN_CH

## Operation
- FSM states:
  - IDLE: on start with a legal cfg, latch cfg and load acc[k] = bias[k], then go to ACCUM. On illegal cfg, pulse cfg_err and stay in IDLE.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&&in_ready. After the last beat is accepted, go to DRAIN.
  - DRAIN: wait one cycle for the pipeline stage, then go to OUT.
  - OUT: out_valid=1. Go to IDLE when out_ready is high.
- Beat count = ceil(cfg_in_ch/NUM_LANES). A beat counter counts accepted beats.
- On the final beat, lanes i ≥ (cfg_in_ch mod NUM_LANES) are masked to zero product. No masking applies when the remainder is 0.
- Stage 1 (registered on beat accept): lane_sum[k] = Σ_i act[i]*wgt[k][i].
  - Products are signed 2*DATA_W.
  - The sum is 2*DATA_W+$clog2(NUM_LANES) bits, sign-extended to ACC_W.
- Stage 2: acc[k] += lane_sum[k] whenever stage-1 valid is set. Two's-complement wrap; no saturation.
- Output: out_data[k] = (cfg_relu && acc[k]<0) ? 0 : acc[k], registered on entry to OUT.
- Output is held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, cfg_err=0; FSM in IDLE; counters and accumulators 0.
- start→in_ready high: 1 cycle.
- Last beat accepted→out_valid high: 3 cycles (stage 1, stage 2, output register). With no stalls, a vector takes beats+4 cycles.
- in_valid gaps stall accumulation only; the stage-1 valid bit carries no bubble corruption.
- start while busy is ignored; no cfg resample and no cfg_err.
- out_ready may be high before out_valid; the handshake completes in the first OUT cycle.
- busy drops in the cycle after the output handshake. start is accepted again in that same cycle.
- Reset mid-operation aborts immediately to reset values. Partial accumulations are discarded.

## Structure
- Shared package pw_conv_pkg holds:
  - the state_t enum (IDLE, ACCUM, DRAIN, OUT)
  - default widths
  - a function ceil_div for the beat count
- One natural sub-module: pw_dot_lane (one OC's NUM_LANES signed multiply, mask and adder tree, with the stage-1 register). It is instantiated NUM_OC times.

## Test plan
- cfg_in_ch=16, relu=0, bias=0; acts all 1, weights of OC k all (k+1) → out_data = {16,32,48,64}, out_valid 3 cycles after the beat.
- cfg_in_ch=20; 2 beats, second beat's lanes 4–15 carry 127 garbage; acts=2, wgt=3 → all outputs 120 (garbage masked).
- acts=-128, wgt=127, cfg_in_ch=16, bias=-5, relu=1 → 0; same with relu=0 → -260101.
- cfg_in_ch=32 with in_valid toggling every other cycle and out_ready held low 5 cycles → correct sum, out_data stable while stalled, in_ready=0 in OUT.
- start with cfg_in_ch=0 → cfg_err pulse, busy stays 0; start during ACCUM → ignored, result unchanged.
- Reset asserted after the first of 3 beats, then a new 1-beat job → the result reflects only the new job.
